// File: rtl/io_port_arbiter.sv
// io_port_arbiter: shares one io_ports instance between N_REQ bus masters.
// Each transaction runs Idle -> Issue -> Capture -> Done (4 cycles):
//   Issue   : one-cycle write_en or read_en strobe to io_ports
//   Capture : io_ports out_data registered into rdata for reads
//   Done    : one-cycle ack to the granted requester
// Build option: define IO_ARB_FIXED_PRIO_EN for fixed priority, where the lowest
// active index always wins. The default build is round-robin, starting after
// last_grant. Latency and FSM are the same in both builds.
module io_port_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 4,
  parameter int IDX_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        rw,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic                    io_write_en,
  output logic                    io_read_en,
  output logic [DATA_W-1:0]       io_in_data,
  input  logic [DATA_W-1:0]       io_out_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StDone} state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    grant_q;
  logic                rw_q;
  logic [N_REQ-1:0]    ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   in_data_q;
  logic                wr_en_q;
  logic                rd_en_q;

  // Arbitration result for the current cycle (only acted on in Idle)
  logic                win_vld;
  logic [IDX_W-1:0]    win_idx;
  logic                win_rw;
  logic [DATA_W-1:0]   win_wdata;
  logic [N_REQ-1:0]    grant_oh;

`ifdef IO_ARB_FIXED_PRIO_EN

  // Fixed priority: the lowest active index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

`else

  logic [IDX_W-1:0] last_grant_q;
  int               rr_dist;
  int               rr_best;

  // Round-robin: the winner is the active index closest above last_grant, with
  // wrap-around. rr_dist is 0 for last_grant+1 and N_REQ-1 for last_grant itself.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_best = N_REQ;
    rr_dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      rr_dist = (i + 2 * N_REQ - 1 - int'(last_grant_q)) % N_REQ;
      if (req[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

`endif

  // Pick out the winner's direction and data, and decode the held grant to one-hot.
  always_comb begin
    win_rw    = 1'b0;
    win_wdata = '0;
    grant_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_rw    = rw[i];
        win_wdata = wdata[i*DATA_W +: DATA_W];
      end
      grant_oh[i] = (grant_q == IDX_W'(i));
    end
  end

  // Transaction sequencer. Strobes and ack default low and pulse for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      rw_q         <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      in_data_q    <= '0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
`ifndef IO_ARB_FIXED_PRIO_EN
      last_grant_q <= IDX_W'(N_REQ - 1);
`endif
    end else begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      ack_q   <= '0;
      unique case (state_q)
        StIdle: begin
          if (win_vld) begin
            grant_q      <= win_idx;
            rw_q         <= win_rw;
`ifndef IO_ARB_FIXED_PRIO_EN
            last_grant_q <= win_idx;
`endif
            // Latch write data now; later wdata changes do not reach io_ports.
            if (win_rw) begin
              wr_en_q   <= 1'b1;
              in_data_q <= win_wdata;
            end else begin
              rd_en_q   <= 1'b1;
            end
            state_q <= StIssue;
          end
        end
        StIssue: begin
          state_q <= StCapture;
        end
        StCapture: begin
          // io_ports updated out_data on the Issue edge, so it is stable here.
          if (!rw_q) begin
            rdata_q <= io_out_data;
          end
          ack_q   <= grant_oh;
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign busy       = (state_q != StIdle);
  assign io_in_data = in_data_q;
  // rst suppresses a strobe already in flight, so a write issued in the same
  // cycle as reset never reaches io_ports.
  assign io_write_en = wr_en_q & ~rst;
  assign io_read_en  = rd_en_q & ~rst;

endmodule
